mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 184 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative 32-bit multiply / divide unit with HI/LO result registers.
//   One operation takes 33 RUN cycles: the first cycle converts the latched
//   operands to magnitudes and seeds the accumulator. Each of the next 32
//   cycles does one shift-add (multiply) or restoring shift-subtract (divide)
//   step. The last step also loads the sign-corrected result into hi/lo.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        request a new operation (accepted in IDLE or DONE)
//   op[1:0]      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b         32-bit operands
//   we_hi/we_lo  direct write of hi/lo with wdata (ignored while busy)
//   wdata        data for the direct writes
//   busy         high while an operation runs
//   done         one-cycle completion pulse
//   div_by_zero  last divide had b==0 (only meaningful while done)
//   hi, lo       result registers
// ---------------------------------------------------------------------------
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  count_reg;
  logic [1:0]  op_reg;
  logic [31:0] a_reg, b_reg;
  logic [31:0] m_reg;        // multiplicand magnitude or divisor magnitude
  logic [63:0] acc_reg;      // product shifter, or {remainder, quotient}
  logic [63:0] acc_next;
  logic        dbz_reg;
  logic [31:0] hi_reg, lo_reg;

  logic        is_div, is_signed, accept, last_iter, b_zero;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_cand;
  logic [31:0] div_sub;
  logic        div_ge;
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s;
  logic [31:0] res_hi, res_lo;

  assign is_div    = op_reg[1];
  assign is_signed = op_reg[0];
  assign b_zero    = (b_reg == 32'd0);
  assign accept    = start && (state_reg != S_RUN);
  // count 0 is the setup cycle; counts 1..32 are the 32 iterations
  assign last_iter = (state_reg == S_RUN) && (count_reg == 6'd32);

  // Operand magnitudes, derived from the latched operands.
  always_comb begin
    a_neg = is_signed & a_reg[31];
    b_neg = is_signed & b_reg[31];
    a_mag = a_neg ? -a_reg : a_reg;
    b_mag = b_neg ? -b_reg : b_reg;
  end

  // One iteration step.
  always_comb begin
    // multiply: add multiplicand to upper half if LSB of multiplier set, shift right
    mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, m_reg} : 33'd0);
    // divide: remainder shifted left with next dividend bit; subtract if it fits
    div_cand = acc_reg[63:31];
    div_ge   = (div_cand >= {1'b0, m_reg});
    div_sub  = div_cand[31:0] - m_reg;   // exact when div_ge, result < divisor
    if (is_div) begin
      if (div_ge) acc_next = {div_sub, acc_reg[30:0], 1'b1};
      else        acc_next = {div_cand[31:0], acc_reg[30:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc_reg[31:1]};
    end
  end

  // Sign correction of the final accumulator value.
  always_comb begin
    prod_s = (a_neg ^ b_neg) ? -acc_next : acc_next;
    quo_s  = (a_neg ^ b_neg) ? -acc_next[31:0] : acc_next[31:0];
    rem_s  = a_neg ? -acc_next[63:32] : acc_next[63:32];
    if (!is_div) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (b_zero) begin
      res_hi = a_reg;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem_s;
      res_lo = quo_s;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (count_reg == 6'd32) state_next = S_DONE;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state_reg)
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        done        = 1'b1;
        div_by_zero = dbz_reg;
      end
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 6'd0;
      op_reg    <= 2'd0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      m_reg     <= 32'd0;
      acc_reg   <= 64'd0;
      dbz_reg   <= 1'b0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
    end else begin
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        op_reg    <= op;
        count_reg <= 6'd0;
      end else if (state_reg == S_RUN) begin
        count_reg <= count_reg + 6'd1;
        if (count_reg == 6'd0) begin
          m_reg   <= is_div ? b_mag : a_mag;
          acc_reg <= {32'd0, (is_div ? a_mag : b_mag)};
        end else begin
          acc_reg <= acc_next;
        end
      end

      if (last_iter) begin
        hi_reg  <= res_hi;
        lo_reg  <= res_lo;
        dbz_reg <= is_div && b_zero;
      end else if (state_reg != S_RUN) begin
        if (we_hi) hi_reg <= wdata;
        if (we_lo) lo_reg <= wdata;
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit. A reference model computes results
//   with plain 64-bit arithmetic and tracks a countdown of cycles until
//   completion; a compare process checks every DUT output on every falling
//   edge. Directed scenarios add hand-computed literal checks, followed by a
//   randomized phase.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clk, rst, start, we_hi, we_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: returns {div_by_zero, hi, lo}
  function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = {32'd0, x} * {32'd0, y}; return {1'b0, p}; end
      2'b01: begin p = sx * sy; return {1'b0, p}; end
      default: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == 2'b10) return {1'b0, x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Behavioural model: cycles left until completion, plus expected registers
  int          run_left;
  logic        m_done, m_dbz;
  logic [31:0] m_hi, m_lo;
  logic [64:0] p_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run_left <= 0;
      m_done   <= 1'b0;
      m_dbz    <= 1'b0;
      m_hi     <= 32'd0;
      m_lo     <= 32'd0;
      p_res    <= 65'd0;
    end else if (run_left != 0) begin
      run_left <= run_left - 1;
      m_done   <= (run_left == 1);
      if (run_left == 1) {m_dbz, m_hi, m_lo} <= p_res;
    end else begin
      m_done <= 1'b0;
      if (we_hi) m_hi <= wdata;
      if (we_lo) m_lo <= wdata;
      if (start) begin
        run_left <= 33;
        p_res    <= ref_op(op, a, b);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 65'(busy), 65'(run_left != 0));
      check("done", 65'(done), 65'(m_done));
      check("dbz",  65'(div_by_zero), 65'(m_done & m_dbz));
      check("hi",   65'(hi), 65'(m_hi));
      check("lo",   65'(lo), 65'(m_lo));
    end
  end

  // Drives start now (caller is at a falling edge), waits for done, checks
  // latency and literal results. Returns at the done falling edge, start low.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input bit noise);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    check({name, "_accept_busy"}, 65'(busy), 65'd1);
    n = 0;
    while (!done && n < 60) begin
      if (busy) n++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_latency"}, 65'(n), 65'd33);
    check({name, "_done"}, 65'(done), 65'd1);
    check({name, "_hi"}, 65'(hi), 65'(ehi));
    check({name, "_lo"}, 65'(lo), 65'(elo));
    check({name, "_dbz"}, 65'(div_by_zero), 65'(edbz));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    we_hi = 1'b0; we_lo = 1'b0; wdata = 32'd0;

    // pin the reference model with hand-computed values
    check("ref_mult",   ref_op(2'b01, 32'hFFFF_FFFE, 32'd3), {1'b0, 64'hFFFF_FFFF_FFFF_FFFA});
    check("ref_div",    ref_op(2'b11, 32'hFFFF_FFF9, 32'd2), {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
    check("ref_multu",  ref_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 64'hFFFF_FFFE_0000_0001});
    check("ref_divmin", ref_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 64'h0000_0000_8000_0000});
    check("ref_dbz",    ref_op(2'b10, 32'd100, 32'd0), {1'b1, 64'h0000_0064_FFFF_FFFF});

    #1;
    check("rst_busy", 65'(busy), 65'd0);
    check("rst_done", 65'(done), 65'd0);
    check("rst_dbz",  65'(div_by_zero), 65'd0);
    check("rst_hi",   65'(hi), 65'd0);
    check("rst_lo",   65'(lo), 65'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // MULT -2 * 3
    run_op("mult", 2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // DIV -7 / 2, then MULTU started during DONE (no bubble)
    run_op("div", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("b2b_multu", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // DIVU by zero; flag lasts exactly one cycle
    run_op("divz", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk);
    check("divz_flag_drop", 65'(div_by_zero), 65'd0);
    @(negedge clk);

    // DIV min / -1 with start noise during RUN: single done pulse
    run_op("divmin", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
    pulses = 1;
    repeat (10) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("divmin_pulses", 65'(pulses), 65'd1);

    // direct write of hi in IDLE, then the same write while busy
    we_hi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    we_hi = 1'b0;
    check("mthi_idle", 65'(hi), 65'h1234_5678);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd7;
    @(negedge clk);
    start = 1'b0; we_hi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    we_hi = 1'b0;
    check("mthi_busy", 65'(hi), 65'h1234_5678);
    repeat (40) @(negedge clk);
    check("mthi_result", 65'({hi, lo}), 65'd35);

    // reset at RUN cycle 10
    start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFE; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 65'(busy), 65'd0);
    check("midrst_hi",   65'(hi), 65'd0);
    check("midrst_lo",   65'(lo), 65'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 65'(pulses), 65'd0);

    // randomized phase, checked every cycle by the compare process
    repeat (1500) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
      we_hi = ($urandom_range(0, 9) == 0);
      we_lo = ($urandom_range(0, 9) == 0);
      wdata = $urandom;
    end
    @(negedge clk);
    start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
